pattern_step_player: RTL and testbench
======================================

Name: pattern_step_player

Overview:
- Consumer side of the rhythm-pattern loop.
- Holds a play position into a WIDTH-bit pattern word. On each tempo tick it reads the current step bit, emits a one-cycle trigger plus a programmable-length gate for a set bit, then advances.
- Sits between the pattern register and the envelope/oscillator gating logic in the melody toolkit.

Parameters:
- WIDTH, 16, number of pattern steps; must be ≥ 2.
- GATE_BITS, 8, width of gate-length field (cycles).
- IDX_W, $clog2(WIDTH), width of step index (derived; not overridden).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset: one clock; reset is asynchronous and active-low (asserted when 0).
- enable  input  1  1 = accept step ticks; 0 = ticks ignored.
- step_tick  input  1  one-cycle tempo pulse, one step per pulse.
- restart  input  1  synchronous return to step 0.
- pattern  input  WIDTH  step pattern; bit i = step i, 1 = note.
- gate_len  input  GATE_BITS  gate duration in clk cycles.
- trigger  output  1  one-cycle pulse per played note.
- gate  output  1  high for gate_len cycles after a note.
- step_index  output  IDX_W  index of the next step to be read.
- loop_start  output  1  one-cycle pulse when step 0 is consumed.

Behaviour:
- Reset (rst=0, async): step_index=0, gate counter=0, trigger=0, gate=0, loop_start=0. Takes effect immediately, mid-gate included.
- Accepted tick: step_tick=1, enable=1, restart=0 in cycle T. All effects below are visible from T+1.
  - trigger = pattern[step_index] sampled in T.
  - loop_start = (step_index==0 in T), regardless of the pattern bit.
  - step_index = step_index+1, wrapping WIDTH-1 → 0.
  - If the bit is 1, the gate counter loads gate_len.
- Gate counter:
  - gate = (counter != 0).
  - Counter decrements by 1 each cycle while nonzero, so gate is high cycles T+1 … T+gate_len inclusive.
  - Reload beats decrement.
  - A new note while gate is high reloads the counter: gate stays high continuously and a fresh trigger still pulses.
  - gate_len=0: trigger pulses, gate stays low.
- Sampling: pattern and gate_len are sampled only in the accepting tick cycle. Later changes do not affect a gate already in progress.
- trigger and loop_start are single-cycle pulses, deasserted on every other cycle. Back-to-back ticks on consecutive cycles each produce a pulse and advance.
- enable=0: ticks ignored, step_index holds, no trigger. A running gate continues counting down to completion.
- restart=1 (sync): step_index=0, counter=0, gate=0, trigger=0, loop_start=0 next cycle.
  - restart wins over a simultaneous step_tick; that tick is dropped.
  - The first tick after restart plays step 0 and pulses loop_start.
- WIDTH not a power of 2: step_index never exceeds WIDTH-1; wrap is explicit, not overflow.
- Internal state: counter nonzero ⇒ GATING, else IDLE. Tick with set bit → GATING; count reaches 0 → IDLE; restart/reset → IDLE.

Test Plan:
- Reset, then pattern=16'h0001, gate_len=3, enable=1, tick at T → trigger@T+1, loop_start@T+1, gate high T+1..T+3, step_index=1.
- Pattern=16'hAAAA, gate_len=2, 16 ticks 4 cycles apart → triggers only on odd steps (8 total), one loop_start at step 0, step_index back to 0 after tick 16; 17th tick pulses loop_start again.
- Pattern=16'hFFFF, gate_len=5, ticks 3 cycles apart → gate never drops between notes, trigger every tick, gate falls 5 cycles after last tick.
- gate_len=0 with set bit → 1-cycle trigger, gate stays 0; enable=0 with 4 ticks → step_index unchanged, no triggers, running gate (gate_len=10 launched earlier) still completes 10 cycles.
- step_index=7 mid-gate, assert restart together with step_tick → next cycle step_index=0, gate=0, no trigger; following tick plays step 0 with loop_start.
- Pull rst low mid-gate between clock edges → gate, trigger, step_index clear immediately without a clock edge; release → idle at step 0.

Source files
------------

// File: rtl/pattern_step_player.sv
// pattern_step_player
//   Walks a play position through a WIDTH-step pattern word. Each accepted tempo
//   tick reads the current step bit, emits a one-cycle trigger and a gate of
//   gate_len cycles for a set bit, and then advances the position with an
//   explicit wrap at WIDTH-1.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   enable     1 = accept step ticks
//   step_tick  one-cycle tempo pulse
//   restart    synchronous return to step 0, clears any running gate
//   pattern    step pattern, bit i = step i, 1 = note
//   gate_len   gate duration in clk cycles, sampled on the accepting tick
//   trigger    one-cycle pulse per played note
//   gate       high while the gate counter is nonzero
//   step_index index of the next step to be read
//   loop_start one-cycle pulse when step 0 is consumed
module pattern_step_player #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned GATE_BITS = 8,
    localparam int unsigned IDX_W    = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 step_tick,
    input  logic                 restart,
    input  logic [WIDTH-1:0]     pattern,
    input  logic [GATE_BITS-1:0] gate_len,
    output logic                 trigger,
    output logic                 gate,
    output logic [IDX_W-1:0]     step_index,
    output logic                 loop_start
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [GATE_BITS-1:0] cnt_q, cnt_d;
    logic                 trig_q, trig_d;
    logic                 loop_q, loop_d;
    logic                 accept;
    logic                 note;

    // restart drops a coincident tick
    assign accept = step_tick & enable & ~restart;
    assign note   = accept & pattern[idx_q];

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        trig_d = note;
        loop_d = accept & (idx_q == '0);

        if (restart) begin
            idx_d = '0;
            cnt_d = '0;
        end else begin
            if (accept) begin
                // explicit wrap so non-power-of-2 widths never overrun
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
            // a fresh note reloads the counter ahead of the decrement
            if (note) begin
                cnt_d = gate_len;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - GATE_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            trig_q <= 1'b0;
            loop_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            trig_q <= trig_d;
            loop_q <= loop_d;
        end
    end

    // gate follows the registered counter, so reset clears it immediately
    assign gate       = (cnt_q != '0);
    assign trigger    = trig_q;
    assign loop_start = loop_q;
    assign step_index = idx_q;

endmodule

// File: tb/tb_pattern_step_player.sv
// Directed bench for pattern_step_player with hand-computed expectations.
module tb_pattern_step_player;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        step_tick;
    logic        restart;
    logic [15:0] pattern;
    logic [7:0]  gate_len;
    logic        trigger;
    logic        gate;
    logic [3:0]  step_index;
    logic        loop_start;

    int checks = 0;
    int errors = 0;

    pattern_step_player #(
        .WIDTH     (16),
        .GATE_BITS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .step_tick  (step_tick),
        .restart    (restart),
        .pattern    (pattern),
        .gate_len   (gate_len),
        .trigger    (trigger),
        .gate       (gate),
        .step_index (step_index),
        .loop_start (loop_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance one clock; sample #1 after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // one-cycle tick; returns with outputs of the following cycle visible
    task automatic tick();
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
    endtask

    int trig_cnt;
    int loop_cnt;
    int gate_bad;
    logic [3:0] held_idx;

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        step_tick = 1'b0;
        restart   = 1'b0;
        pattern   = '0;
        gate_len  = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_trigger", 32'(trigger), 0);
        check("rst_gate", 32'(gate), 0);
        check("rst_idx", 32'(step_index), 0);
        check("rst_loop", 32'(loop_start), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // single note on step 0
        pattern  = 16'h0001;
        gate_len = 8'd3;
        enable   = 1'b1;
        cyc();
        tick();
        check("t1_trigger", 32'(trigger), 1);
        check("t1_loop", 32'(loop_start), 1);
        check("t1_gate_t1", 32'(gate), 1);
        check("t1_idx", 32'(step_index), 1);
        cyc();
        check("t1_trigger_pulse", 32'(trigger), 0);
        check("t1_gate_t2", 32'(gate), 1);
        cyc();
        check("t1_gate_t3", 32'(gate), 1);
        cyc();
        check("t1_gate_t4", 32'(gate), 0);

        // alternating pattern over a full loop
        do_restart();
        pattern  = 16'hAAAA;
        gate_len = 8'd2;
        trig_cnt = 0;
        loop_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            trig_cnt += int'(trigger);
            loop_cnt += int'(loop_start);
            for (int k = 0; k < 3; k++) begin
                cyc();
                trig_cnt += int'(trigger);
                loop_cnt += int'(loop_start);
            end
        end
        check("aa_triggers", 32'(trig_cnt), 8);
        check("aa_loops", 32'(loop_cnt), 1);
        check("aa_idx_wrap", 32'(step_index), 0);
        tick();
        check("aa_loop17", 32'(loop_start), 1);
        check("aa_trig17", 32'(trigger), 0);
        check("aa_idx17", 32'(step_index), 1);

        // overlapping gates stay high continuously
        do_restart();
        pattern  = 16'hFFFF;
        gate_len = 8'd5;
        trig_cnt = 0;
        gate_bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            trig_cnt += int'(trigger);
            if (gate !== 1'b1) gate_bad++;
            if (i < 5) begin
                for (int k = 0; k < 2; k++) begin
                    cyc();
                    if (gate !== 1'b1) gate_bad++;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (gate !== 1'b1) gate_bad++;
        end
        check("ff_triggers", 32'(trig_cnt), 6);
        check("ff_gate_held", 32'(gate_bad), 0);
        cyc();
        check("ff_gate_fall", 32'(gate), 0);

        // zero gate length
        gate_len = 8'd0;
        tick();
        check("g0_trigger", 32'(trigger), 1);
        check("g0_gate", 32'(gate), 0);
        cyc();
        check("g0_trigger_off", 32'(trigger), 0);
        check("g0_gate_off", 32'(gate), 0);

        // gate launched, then ticks ignored while disabled
        gate_len = 8'd10;
        tick();
        check("en_launch_gate", 32'(gate), 1);
        held_idx = step_index;
        enable   = 1'b0;
        pattern  = 16'h0000;
        gate_len = 8'd1;
        trig_cnt = 0;
        gate_bad = 0;
        for (int c = 2; c <= 11; c++) begin
            step_tick = ((c % 2) == 0) && (c <= 9);
            cyc();
            trig_cnt += int'(trigger);
            if (gate !== (c <= 10)) gate_bad++;
        end
        step_tick = 1'b0;
        check("en_idx_hold", 32'(step_index), 32'(held_idx));
        check("en_no_trigger", 32'(trig_cnt), 0);
        check("en_gate_len10", 32'(gate_bad), 0);
        enable = 1'b1;

        // back-to-back ticks to step 7, then restart with a coincident tick
        do_restart();
        pattern  = 16'hFFFF;
        gate_len = 8'd20;
        trig_cnt = 0;
        step_tick = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            trig_cnt += int'(trigger);
        end
        check("b2b_triggers", 32'(trig_cnt), 7);
        check("b2b_idx", 32'(step_index), 7);
        check("b2b_gate", 32'(gate), 1);
        restart = 1'b1;
        cyc();
        restart   = 1'b0;
        step_tick = 1'b0;
        check("rs_idx", 32'(step_index), 0);
        check("rs_gate", 32'(gate), 0);
        check("rs_trigger", 32'(trigger), 0);
        check("rs_loop", 32'(loop_start), 0);
        tick();
        check("rs_play_trig", 32'(trigger), 1);
        check("rs_play_loop", 32'(loop_start), 1);
        check("rs_play_idx", 32'(step_index), 1);

        // async reset mid-gate, between edges
        gate_len = 8'd10;
        tick();
        check("ar_pre_gate", 32'(gate), 1);
        #2 rst = 1'b0;
        #1;
        check("ar_gate", 32'(gate), 0);
        check("ar_trigger", 32'(trigger), 0);
        check("ar_idx", 32'(step_index), 0);
        #3 rst = 1'b1;
        cyc();
        check("ar_rel_gate", 32'(gate), 0);
        check("ar_rel_idx", 32'(step_index), 0);
        check("ar_rel_trigger", 32'(trigger), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
